uart_rx_timing: RTL and testbench
=================================

# uart_rx_timing

Oversampling timing and sampling front-end of the UART receiver. Counts oversampling clock edges within each bit period, counts completed bit periods, and majority-votes three mid-bit samples of `RX_IN` into a single sampled bit. Sits directly upstream of the RX control FSM, the start/parity/stop checkers and the deserializer. It supplies their `edge_cnt`, `bit_cnt` and `sampled_bit` inputs, and takes `enable`/`dat_samp_en` back from the FSM.

## Interface
- `PRESCALE_W`, default 6: width of `Prescale`.
- `EDGE_W`, default 5: width of `edge_cnt`.
- `BIT_W`, default 4: width of `bit_cnt`.
- `MAX_BITS`, default 11: saturation value of `bit_cnt` (start + 8 data + parity + stop).
- `clk`  in  1  oversampling clock (Prescale × baud); single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, already synchronised; idle high.
- `Prescale`  in  6  oversampling ratio; legal values 8, 16, 32.
- `enable`  in  1  counter enable from FSM.
- `dat_samp_en`  in  1  sampling enable from FSM.
- `edge_cnt`  out  5  edge position within current bit, 0..Prescale-1.
- `bit_cnt`  out  4  number of completed bit periods in current frame.
- `sampled_bit`  out  1  majority-voted value of the current bit.
- `samp_vld`  out  1  one-cycle pulse: `sampled_bit` freshly updated.

## Operation
- Define H = Prescale >> 1, computed 6 bits wide. Compares against `edge_cnt` are zero-extended to 6 bits.
- Edge counter, cycle with `enable`=1:
  - If `edge_cnt` == Prescale-1: `edge_cnt` <= 0.
  - Otherwise: `edge_cnt` <= `edge_cnt`+1.
- Bit counter:
  - Increments on each `edge_cnt` wrap.
  - Saturates at MAX_BITS (11); `edge_cnt` continues to wrap while saturated.
- Any cycle with `enable`=0: `edge_cnt` <= 0 and `bit_cnt` <= 0 on the next edge, regardless of their current value.
- Sampler, active only while `dat_samp_en`=1:
  - `edge_cnt` == H-2: s0 <= `RX_IN`.
  - `edge_cnt` == H-1: s1 <= `RX_IN`.
  - `edge_cnt` == H: `sampled_bit` <= majority(s0, s1, `RX_IN`) = s0&s1 | s0&RX_IN | s1&RX_IN.
- `samp_vld` is registered. It is 1 exactly in the cycle after the `sampled_bit` update, i.e. while `edge_cnt` == H+1 with `dat_samp_en` still 1.
- With `dat_samp_en`=0:
  - s0, s1 and `sampled_bit` hold their values.
  - `samp_vld` = 0.
- Counters still run if `enable`=1, independent of `dat_samp_en`.
- Illegal `Prescale` (not 8/16/32) is unsupported but must not lock up:
  - Wrap point is min(Prescale-1, 31).
  - Prescale < 4 is never sampled.
- A `Prescale` change mid-frame takes effect on the next compare. Frame integrity is not guaranteed.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `edge_cnt` = 0, `bit_cnt` = 0.
  - s0 = s1 = 1, `sampled_bit` = 1 (idle line).
  - `samp_vld` = 0.
- Reset mid-frame clears all state. On release, counting restarts only when `enable`=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The FSM asserts `enable` combinationally in the IDLE cycle where `RX_IN` falls. Therefore `edge_cnt` = 1 in the first START_BIT cycle, and bit periods align to the detected falling edge.
- `sampled_bit` is stable throughout `edge_cnt` == H+1. This is the cycle where the FSM pulses `strt_chk_en`/`par_chk_en`/`stp_chk_en`; checkers must read `sampled_bit` there.
- `bit_cnt` transitions k→k+1 on the edge where `edge_cnt` goes Prescale-1→0.
- Expected `bit_cnt` values at the FSM:
  - 1 on entering data bits.
  - 9 after the 8th data bit.
  - 10 after parity.
- Simultaneous wrap and `enable` falling: the clear wins; `bit_cnt` is not incremented.

## Structure
- Shared package `uart_rx_pkg`:
  - PRESCALE_8/16/32 constants.
  - MAX_BITS = 11.
  - EDGE_W, BIT_W, PRESCALE_W widths.
- Also used by the FSM and checkers.
- Two natural sub-modules:
  - `edge_bit_counter`: edge and bit counters.
  - `data_sampler`: s0/s1, majority vote, `samp_vld`.
- The top instantiates both and shares H between them.

## Test plan
- Prescale=8, `enable`=1 held 24 cycles.
  - `edge_cnt` runs 1..7,0 three times.
  - `bit_cnt` = 1, 2, 3 after cycles 8, 16, 24.
- Prescale=16, frame byte 0xA5, no parity; FSM model drives enable/dat_samp_en.
  - `sampled_bit` at each `edge_cnt`==9 cycle reads 0 (start), 1,0,1,0,0,1,0,1 (LSB first), 1 (stop).
  - `samp_vld` pulses 10 times.
- Prescale=16, single-cycle low glitch on `RX_IN` at `edge_cnt`==7 of a data-1 bit.
  - `sampled_bit` = 1 (2-of-3 vote).
  - A 2-cycle glitch at `edge_cnt`==6..7 yields 0.
- Prescale=32, `enable` held 400 cycles.
  - `bit_cnt` saturates at 11.
  - `edge_cnt` keeps wrapping 0..31 with no overflow of its 5 bits.
- `enable` dropped on the same cycle as `edge_cnt`==Prescale-1 with `bit_cnt`=4.
  - Next cycle `edge_cnt`=0, `bit_cnt`=0, no increment to 5.
- `rst_n` asserted mid-data-bit (`edge_cnt`=5, `bit_cnt`=3, `sampled_bit`=0).
  - Outputs go immediately to 0/0/1, `samp_vld`=0.
  - They stay there until `enable` returns.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: widths, legal oversampling ratios,
// frame length and the 2-of-3 majority vote used on mid-bit samples.
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;
    localparam int EDGE_W     = 5;
    localparam int BIT_W      = 4;
    localparam int MAX_BITS   = 11;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_timing_counter.sv
// Edge-within-bit counter and completed-bit counter for the UART receiver.
// The wrap point is clamped to the edge counter range so odd Prescale values cannot lock it up.
module edge_bit_counter #(
    parameter int PRESCALE_W = 6,
    parameter int EDGE_W     = 5,
    parameter int BIT_W      = 4,
    parameter int MAX_BITS   = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    output logic [EDGE_W-1:0]     edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt
);
    import uart_rx_pkg::*;

    localparam logic [PRESCALE_W-1:0] EDGE_MAX_P = PRESCALE_W'((2 ** EDGE_W) - 1);
    localparam logic [EDGE_W-1:0]     EDGE_MAX_E = {EDGE_W{1'b1}};
    localparam logic [BIT_W-1:0]      BIT_SAT    = BIT_W'(MAX_BITS);

    logic [PRESCALE_W-1:0] pm1_s;
    logic [EDGE_W-1:0]     wrap_pt_s;
    logic [EDGE_W-1:0]     edge_cnt_d, edge_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_d, bit_cnt_q;

    // Next-state for both counters; a dropped enable clears them and beats a coincident wrap.
    always_comb begin
        pm1_s      = prescale - PRESCALE_W'(1);
        wrap_pt_s  = EDGE_MAX_E;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if ((prescale == {PRESCALE_W{1'b0}}) || (pm1_s > EDGE_MAX_P)) begin
            wrap_pt_s = EDGE_MAX_E;
        end else begin
            wrap_pt_s = pm1_s[EDGE_W-1:0];
        end
        if (!enable) begin
            edge_cnt_d = {EDGE_W{1'b0}};
            bit_cnt_d  = {BIT_W{1'b0}};
        end else if (edge_cnt_q == wrap_pt_s) begin
            edge_cnt_d = {EDGE_W{1'b0}};
            if (bit_cnt_q < BIT_SAT) begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else begin
                bit_cnt_d = BIT_SAT;
            end
        end else begin
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
            bit_cnt_d  = bit_cnt_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= {EDGE_W{1'b0}};
            bit_cnt_q  <= {BIT_W{1'b0}};
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_timing_sampler.sv
// Mid-bit sampler: captures RX at half-2 and half-1, votes with RX at half,
// and flags the fresh result for one cycle.
module data_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int EDGE_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] half,
    input  logic                  samp_ok,
    input  logic [EDGE_W-1:0]     edge_cnt,
    input  logic                  rx_in,
    input  logic                  dat_samp_en,
    output logic                  sampled_bit,
    output logic                  samp_vld
);
    import uart_rx_pkg::*;

    logic [PRESCALE_W-1:0] edge_ext_s;
    logic s0_d, s0_q;
    logic s1_d, s1_q;
    logic sampled_bit_d, sampled_bit_q;
    logic samp_vld_d, samp_vld_q;

    // Sample capture and vote; everything holds while sampling is disabled.
    always_comb begin
        edge_ext_s    = PRESCALE_W'(edge_cnt);
        s0_d          = s0_q;
        s1_d          = s1_q;
        sampled_bit_d = sampled_bit_q;
        samp_vld_d    = 1'b0;
        if (dat_samp_en && samp_ok) begin
            if (edge_ext_s == (half - PRESCALE_W'(2))) begin
                s0_d = rx_in;
            end else if (edge_ext_s == (half - PRESCALE_W'(1))) begin
                s1_d = rx_in;
            end else if (edge_ext_s == half) begin
                sampled_bit_d = majority3(s0_q, s1_q, rx_in);
                samp_vld_d    = 1'b1;
            end else begin
                samp_vld_d = 1'b0;
            end
        end else begin
            samp_vld_d = 1'b0;
        end
    end

    // Sampler registers; reset to the idle-line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            sampled_bit_q <= 1'b1;
            samp_vld_q    <= 1'b0;
        end else begin
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            sampled_bit_q <= sampled_bit_d;
            samp_vld_q    <= samp_vld_d;
        end
    end

    assign sampled_bit = sampled_bit_q;
    assign samp_vld    = samp_vld_q;

endmodule

// File: rtl/uart_rx_timing.sv
// UART RX oversampling front-end: edge/bit counters plus 3-sample majority sampler.
// Half the prescale is computed once here and shared with the sampler.
module uart_rx_timing #(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int EDGE_W     = uart_rx_pkg::EDGE_W,
    parameter int BIT_W      = uart_rx_pkg::BIT_W,
    parameter int MAX_BITS   = uart_rx_pkg::MAX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  enable,
    input  logic                  dat_samp_en,
    output logic [EDGE_W-1:0]     edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  sampled_bit,
    output logic                  samp_vld
);
    import uart_rx_pkg::*;

    logic [PRESCALE_W-1:0] half_s;
    logic                  samp_ok_s;

    // Ratios below 4 leave no room for three samples, so they never sample.
    assign half_s    = Prescale >> 1;
    assign samp_ok_s = (Prescale >= PRESCALE_W'(4));

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .EDGE_W     (EDGE_W),
        .BIT_W      (BIT_W),
        .MAX_BITS   (MAX_BITS)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .prescale (Prescale),
        .enable   (enable),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    data_sampler #(
        .PRESCALE_W (PRESCALE_W),
        .EDGE_W     (EDGE_W)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .half        (half_s),
        .samp_ok     (samp_ok_s),
        .edge_cnt    (edge_cnt),
        .rx_in       (RX_IN),
        .dat_samp_en (dat_samp_en),
        .sampled_bit (sampled_bit),
        .samp_vld    (samp_vld)
    );

endmodule

// File: tb/tb_uart_rx_timing.sv
// Directed bench for uart_rx_timing: counter checks inline, sampled bits via a
// scoreboard queue popped by a monitor whenever samp_vld is seen.
module tb_uart_rx_timing;

    logic       clk;
    logic       rst_n;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       enable;
    logic       dat_samp_en;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       samp_vld;

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   vld_count = 0;
    logic exp_q[$];

    uart_rx_timing dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .enable      (enable),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (sampled_bit),
        .samp_vld    (samp_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every samp_vld pulse must match the next expected sampled bit.
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (samp_vld === 1'b1) begin
                vld_count++;
                check("vld_edge", {27'd0, edge_cnt}, {26'd0, Prescale >> 1} + 32'd1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_vld: got samp_vld=1, expected no pulse at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sampled_bit", {31'd0, sampled_bit}, {31'd0, e});
                end
            end
        end
    end

    initial begin
        logic [9:0] frame;
        int         v0;
        rst_n       = 1'b0;
        RX_IN       = 1'b1;
        enable      = 1'b0;
        dat_samp_en = 1'b0;
        Prescale    = 6'd8;
        #12;
        check("rst_edge", {27'd0, edge_cnt}, 32'd0);
        check("rst_bit", {28'd0, bit_cnt}, 32'd0);
        check("rst_sb", {31'd0, sampled_bit}, 32'd1);
        check("rst_vld", {31'd0, samp_vld}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Prescale 8, 24 enabled cycles
        enable = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check("p8_edge", {27'd0, edge_cnt}, i % 8);
            check("p8_bit", {28'd0, bit_cnt}, i / 8);
        end
        enable = 1'b0;
        tick();
        check("p8_clr_edge", {27'd0, edge_cnt}, 32'd0);
        check("p8_clr_bit", {28'd0, bit_cnt}, 32'd0);

        // Prescale 16, frame 0xA5: start, LSB-first data, stop
        Prescale = 6'd16;
        repeat (3) tick();
        v0          = vld_count;
        frame       = {1'b1, 8'hA5, 1'b0};
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            RX_IN = frame[j];
            exp_q.push_back(frame[j]);
            repeat (16) tick();
        end
        check("frame_bit_cnt", {28'd0, bit_cnt}, 32'd10);
        check("frame_edge", {27'd0, edge_cnt}, 32'd0);
        enable      = 1'b0;
        dat_samp_en = 1'b0;
        RX_IN       = 1'b1;
        repeat (2) tick();
        check("frame_vld_count", vld_count - v0, 32'd10);

        // Glitches: 2-cycle low at edge 6..7 votes 0, 1-cycle low at edge 7 votes 1
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        exp_q.push_back(1'b0);
        for (int k = 1; k <= 16; k++) begin
            RX_IN = (k == 7 || k == 8) ? 1'b0 : 1'b1;
            tick();
        end
        exp_q.push_back(1'b1);
        for (int k = 1; k <= 16; k++) begin
            RX_IN = (k == 8) ? 1'b0 : 1'b1;
            tick();
        end
        check("glitch_sb", {31'd0, sampled_bit}, 32'd1);
        enable      = 1'b0;
        dat_samp_en = 1'b0;
        RX_IN       = 1'b1;
        tick();

        // Prescale 32, 400 cycles: bit_cnt saturates, edge keeps wrapping
        Prescale = 6'd32;
        enable   = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            check("p32_edge", {27'd0, edge_cnt}, i % 32);
            check("p32_bit", {28'd0, bit_cnt}, (i / 32 > 11) ? 11 : i / 32);
        end
        enable = 1'b0;
        tick();

        // Enable drops on the wrap cycle with bit_cnt=4: clear wins
        Prescale = 6'd8;
        enable   = 1'b1;
        repeat (39) tick();
        check("drop_pre_edge", {27'd0, edge_cnt}, 32'd7);
        check("drop_pre_bit", {28'd0, bit_cnt}, 32'd4);
        enable = 1'b0;
        tick();
        check("drop_edge", {27'd0, edge_cnt}, 32'd0);
        check("drop_bit", {28'd0, bit_cnt}, 32'd0);

        // Reset mid-data-bit at edge 5, bit 3, sampled_bit 0
        Prescale    = 6'd16;
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        RX_IN       = 1'b0;
        for (int j = 0; j < 3; j++) exp_q.push_back(1'b0);
        repeat (53) tick();
        check("pre_rst_edge", {27'd0, edge_cnt}, 32'd5);
        check("pre_rst_bit", {28'd0, bit_cnt}, 32'd3);
        check("pre_rst_sb", {31'd0, sampled_bit}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_edge", {27'd0, edge_cnt}, 32'd0);
        check("async_rst_bit", {28'd0, bit_cnt}, 32'd0);
        check("async_rst_sb", {31'd0, sampled_bit}, 32'd1);
        check("async_rst_vld", {31'd0, samp_vld}, 32'd0);
        enable      = 1'b0;
        dat_samp_en = 1'b0;
        RX_IN       = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_edge", {27'd0, edge_cnt}, 32'd0);
        check("post_rst_bit", {28'd0, bit_cnt}, 32'd0);
        check("post_rst_sb", {31'd0, sampled_bit}, 32'd1);
        enable = 1'b1;
        tick();
        check("restart_edge", {27'd0, edge_cnt}, 32'd1);
        enable = 1'b0;
        repeat (2) tick();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
